// File: rtl/alu_multicycle.sv
`default_nettype none
// ============================================================================
// Module   : alu_multicycle
// Brief    : Clocked WIDTH-bit ALU with start/busy/done handshake, iterative
//            shift-add MUL and restoring DIV. Flags gated by ALU_FLAGS_EN.
// Revision : 1.0
// ============================================================================
module alu_multicycle #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       select,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             busy,
    output logic             done,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             div_by_zero
);

    localparam logic [2:0] c_op_and = 3'b000;
    localparam logic [2:0] c_op_or  = 3'b001;
    localparam logic [2:0] c_op_add = 3'b010;
    localparam logic [2:0] c_op_sub = 3'b011;
    localparam logic [2:0] c_op_mul = 3'b100;
    localparam logic [2:0] c_op_div = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state, w_next;

    logic [CNT_W-1:0] r_cnt;
    logic             r_is_mul;
    logic [WIDTH-1:0] r_opnd;
    logic [WIDTH-1:0] r_hi, r_lo;
    logic [WIDTH-1:0] r_result, r_result_hi;

    logic             w_accept, w_iter_start, w_last;
    logic [WIDTH:0]   w_add, w_sub, w_mul_sum, w_shift, w_trial;
    logic [WIDTH-1:0] w_hi_n, w_lo_n;
    logic             w_load;
    logic [WIDTH-1:0] w_res, w_res_hi;
    logic             w_zero, w_carry, w_ovf, w_dbz;

    assign w_accept     = start && (r_state != S_RUN);
    assign w_iter_start = (select == c_op_mul) || ((select == c_op_div) && (B != '0));
    assign w_last       = (r_state == S_RUN) && (r_cnt == CNT_W'(1));

    assign w_add = {1'b0, A} + {1'b0, B};
    assign w_sub = {1'b0, A} - {1'b0, B};

    // One iteration step: MUL adds the multiplicand then shifts {carry,hi,lo}
    // right; DIV shifts the next dividend bit into the remainder and trials.
    assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
    assign w_shift   = {r_hi, r_lo[WIDTH-1]};
    assign w_trial   = w_shift - {1'b0, r_opnd};

    always_comb begin
        w_hi_n = '0;
        w_lo_n = '0;
        if (r_is_mul) begin
            w_hi_n = w_mul_sum[WIDTH:1];
            w_lo_n = {w_mul_sum[0], r_lo[WIDTH-1:1]};
        end else if (!w_trial[WIDTH]) begin
            w_hi_n = w_trial[WIDTH-1:0];
            w_lo_n = {r_lo[WIDTH-2:0], 1'b1};
        end else begin
            w_hi_n = w_shift[WIDTH-1:0];
            w_lo_n = {r_lo[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept) w_next = w_iter_start ? S_RUN : S_DONE;
                else          w_next = S_IDLE;
            end
            S_RUN:   if (w_last) w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    // Result/flag values to be captured at the cycle an op completes.
    always_comb begin
        w_load   = 1'b0;
        w_res    = '0;
        w_res_hi = '0;
        w_carry  = 1'b0;
        w_ovf    = 1'b0;
        w_dbz    = 1'b0;
        if (w_last) begin
            w_load   = 1'b1;
            w_res    = w_lo_n;
            w_res_hi = w_hi_n;
            w_ovf    = r_is_mul && (w_hi_n != '0);
        end else if (w_accept && !w_iter_start) begin
            w_load = 1'b1;
            case (select)
                c_op_and: w_res = A & B;
                c_op_or:  w_res = A | B;
                c_op_add: begin
                    w_res   = w_add[WIDTH-1:0];
                    w_carry = w_add[WIDTH];
                    w_ovf   = (A[WIDTH-1] == B[WIDTH-1]) && (w_add[WIDTH-1] != A[WIDTH-1]);
                end
                c_op_sub: begin
                    w_res   = w_sub[WIDTH-1:0];
                    w_carry = w_sub[WIDTH];
                    w_ovf   = (A[WIDTH-1] != B[WIDTH-1]) && (w_sub[WIDTH-1] != A[WIDTH-1]);
                end
                c_op_div: begin
                    w_res    = '1;
                    w_res_hi = A;
                    w_dbz    = 1'b1;
                end
                default: ;
            endcase
        end
        w_zero = (w_res == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_is_mul    <= 1'b0;
            r_opnd      <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_result    <= '0;
            r_result_hi <= '0;
        end else begin
            if (w_accept && w_iter_start) begin
                r_cnt    <= CNT_W'(WIDTH);
                r_is_mul <= (select == c_op_mul);
                r_opnd   <= (select == c_op_mul) ? A : B;
                r_hi     <= '0;
                r_lo     <= (select == c_op_mul) ? B : A;
            end else if (r_state == S_RUN) begin
                r_hi <= w_hi_n;
                r_lo <= w_lo_n;
                if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_load) begin
                r_result    <= w_res;
                r_result_hi <= w_res_hi;
            end
        end
    end

    assign result    = r_result;
    assign result_hi = r_result_hi;
    assign busy      = (r_state == S_RUN);
    assign done      = (r_state == S_DONE);

`ifdef ALU_FLAGS_EN
    logic r_zero, r_carry, r_ovf, r_dbz;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_zero  <= 1'b0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
            r_dbz   <= 1'b0;
        end else if (w_load) begin
            r_zero  <= w_zero;
            r_carry <= w_carry;
            r_ovf   <= w_ovf;
            r_dbz   <= w_dbz;
        end
    end

    assign zero        = r_zero;
    assign carry       = r_carry;
    assign overflow    = r_ovf;
    assign div_by_zero = r_dbz;
`else
    logic w_unused_flags;
    assign w_unused_flags = ^{w_zero, w_carry, w_ovf, w_dbz};

    assign zero        = 1'b0;
    assign carry       = 1'b0;
    assign overflow    = 1'b0;
    assign div_by_zero = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_multicycle.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_multicycle
// Brief    : Scoreboard bench for alu_multicycle (WIDTH=16), directed vectors.
// Revision : 1.0
// ============================================================================
module tb_alu_multicycle;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   select;
    logic [W-1:0] A, B;
    logic [W-1:0] result, result_hi;
    logic         busy, done, zero, carry, overflow, div_by_zero;

    alu_multicycle #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .select(select), .A(A), .B(B),
        .result(result), .result_hi(result_hi), .busy(busy), .done(done),
        .zero(zero), .carry(carry), .overflow(overflow), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         z, c, o, d;
        int           lat;
        int           due;
    } exp_t;

    exp_t         q[$];
    int           checks   = 0;
    int           failures = 0;
    int           cyc      = 0;
    logic [W-1:0] last_res = '0;
    logic [W-1:0] last_hi  = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic fl(input logic f);
`ifdef ALU_FLAGS_EN
        return f;
`else
        return 1'b0 & f;
`endif
    endfunction

    function automatic exp_t mk(input logic [W-1:0] r, input logic [W-1:0] h,
                                input logic z, input logic c, input logic o,
                                input logic d, input int lat);
        exp_t e;
        e.res = r; e.hi = h;
        e.z = fl(z); e.c = fl(c); e.o = fl(o); e.d = fl(d);
        e.lat = lat; e.due = 0;
        return e;
    endfunction

    // Monitor: compares every done pulse against the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            chk("busy_done_excl", {31'd0, busy && done}, 32'd0);
            if (busy) begin
                chk("hold_result", result, last_res);
                chk("hold_result_hi", result_hi, last_hi);
                if (q.size() > 0 && q[0].lat == 1) chk("busy_single_op", {31'd0, busy}, 32'd0);
            end
            if (done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", result, 32'hDEAD_BEEF);
                end else begin
                    e = q.pop_front();
                    chk("latency_cycle", cyc, e.due);
                    chk("result", result, e.res);
                    chk("result_hi", result_hi, e.hi);
                    chk("zero", zero, e.z);
                    chk("carry", carry, e.c);
                    chk("overflow", overflow, e.o);
                    chk("div_by_zero", div_by_zero, e.d);
                    last_res = e.res;
                    last_hi  = e.hi;
                end
            end
        end
    end

    // Drives one request; returns just after the accepting edge with start low.
    task automatic issue(input logic [2:0] s, input logic [W-1:0] a, input logic [W-1:0] b,
                         input exp_t e, input bit push);
        select = s; A = a; B = b; start = 1'b1;
        @(posedge clk);
        #1;
        e.due = cyc + e.lat - 1;
        if (push) q.push_back(e);
        start = 1'b0;
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (q.size() == 0 && !busy && !done) ok = 1'b1;
        end
        if (!ok) chk("drain_timeout", q.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; select = '0; A = '0; B = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_result", result, 0);
        chk("reset_result_hi", result_hi, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_flags", {zero, carry, overflow, div_by_zero}, 0);
        rst = 1'b0;
        @(negedge clk);

        issue(3'b010, 16'hFFFF, 16'h0001, mk(16'h0000, 16'h0000, 1, 1, 0, 0, 1), 1);
        drain();
        issue(3'b011, 16'h0003, 16'h0005, mk(16'hFFFE, 16'h0000, 0, 1, 0, 0, 1), 1);
        issue(3'b000, 16'h0F0F, 16'h00FF, mk(16'h000F, 16'h0000, 0, 0, 0, 0, 1), 1);
        drain();
        issue(3'b001, 16'hA000, 16'h0005, mk(16'hA005, 16'h0000, 0, 0, 0, 0, 1), 1);
        drain();
        issue(3'b010, 16'h7FFF, 16'h0001, mk(16'h8000, 16'h0000, 0, 0, 1, 0, 1), 1);
        drain();
        issue(3'b011, 16'h8000, 16'h0001, mk(16'h7FFF, 16'h0000, 0, 0, 1, 0, 1), 1);
        drain();
        issue(3'b110, 16'h1234, 16'h5678, mk(16'h0000, 16'h0000, 1, 0, 0, 0, 1), 1);
        drain();

        // MUL with an ignored start pulse in the middle of RUN
        issue(3'b100, 16'h1234, 16'h0100, mk(16'h3400, 16'h0012, 0, 0, 1, 0, 17), 1);
        repeat (5) @(negedge clk);
        select = 3'b010; A = 16'h0001; B = 16'h0001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();
        issue(3'b100, 16'hFFFF, 16'hFFFF, mk(16'h0001, 16'hFFFE, 0, 0, 1, 0, 17), 1);
        drain();

        // DIV with operands changed right after accept
        issue(3'b101, 16'd100, 16'd7, mk(16'd14, 16'd2, 0, 0, 0, 0, 17), 1);
        select = 3'b000; A = 16'hAAAA; B = 16'h0003;
        drain();
        issue(3'b101, 16'd7, 16'd9, mk(16'd0, 16'd7, 1, 0, 0, 0, 17), 1);
        drain();
        issue(3'b101, 16'h0055, 16'h0000, mk(16'hFFFF, 16'h0055, 0, 0, 0, 1, 1), 1);
        drain();

        // Abort a DIV with reset part-way through RUN
        issue(3'b101, 16'hFFFF, 16'h0003, mk(16'h5555, 16'h0000, 0, 0, 0, 0, 17), 0);
        repeat (4) @(negedge clk);
        chk("abort_busy_before", busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_result", result, 0);
        chk("abort_result_hi", result_hi, 0);
        chk("abort_flags", {zero, carry, overflow, div_by_zero}, 0);
        @(negedge clk);
        rst = 1'b0;
        last_res = '0;
        last_hi  = '0;
        @(negedge clk);
        issue(3'b010, 16'h0002, 16'h0002, mk(16'h0004, 16'h0000, 0, 0, 0, 0, 1), 1);
        drain();

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
